// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder slice built from two half adders; purely combinational.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b;
    assign cout = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);
    logic s1, c1, c2;

    half_adder u_ha0 (.a(a),  .b(b),   .sum(s1),  .cout(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .sum(sum), .cout(c2));

    assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one full-adder
// slice, one bit per clock, behind a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_q;
    logic             carry_q, busy_q, done_q, cout_q;
    logic [CNT_W-1:0] cnt_q;

    logic             fa_s, fa_c;
    logic [WIDTH-1:0] sum_sr_d;
    logic [CNT_W-1:0] cnt_d;

    full_adder u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .cout (fa_c),
        .sum  (fa_s)
    );

    // Widened shift keeps the MSB insert legal when WIDTH is 1.
    always_comb begin
        sum_sr_d = WIDTH'({fa_s, sum_sr_q} >> 1);
        cnt_d    = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        sum_sr_q <= '0;
                        carry_q  <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_sr_q <= sum_sr_d;
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    carry_q  <= fa_c;
                    cnt_q    <= cnt_d;
                    if (cnt_d == CNT_W'(WIDTH)) begin
                        sum_q   <= sum_sr_d;
                        cout_q  <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule
